// File: rtl/cc_pll_rst_seq_if.sv
// rtl/cc_pll_rst_seq_if.sv - PLL lock/reset handshake bundle between CC_PLL side and the reset sequencer
interface cc_pll_rst_seq_if #(
   parameter int CNT_W = 8
);
   logic             pll_locked;
   logic             pll_locked_stdy;
   logic             usr_rstn;
   logic             locked_stdy_rst;
   logic             sys_rst;
   logic             sys_rstn;
   logic             ready;
   logic [CNT_W-1:0] loss_cnt;

   modport master (
      output pll_locked, pll_locked_stdy, usr_rstn,
      input  locked_stdy_rst, sys_rst, sys_rstn, ready, loss_cnt
   );

   modport slave (
      input  pll_locked, pll_locked_stdy, usr_rstn,
      output locked_stdy_rst, sys_rst, sys_rstn, ready, loss_cnt
   );
endinterface

// File: rtl/cc_pll_rst_seq.sv
// rtl/cc_pll_rst_seq.sv - PLL lock/reset sequencer: syncs lock/user reset, sequences SYS_RST, re-arms steady lock
// Optional lock-loss counter built only when CC_RSTSEQ_LOSS_CNT_EN is defined.
module cc_pll_rst_seq #(
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_CYCLES = 256,
   parameter int REARM_CYCLES  = 8,
   parameter int LOCK_TIMEOUT  = 4096,
   parameter int CNT_W         = 8
) (
   input  logic           clk,
   input  logic           rst,
   cc_pll_rst_seq_if.slave bus
);

   localparam int MAX_SR = (SETTLE_CYCLES > REARM_CYCLES) ? SETTLE_CYCLES : REARM_CYCLES;
   localparam int MAX_C  = (MAX_SR > LOCK_TIMEOUT) ? MAX_SR : LOCK_TIMEOUT;
   localparam int TW     = (MAX_C < 1) ? 1 : $clog2(MAX_C + 1);

   typedef enum logic [2:0] {
      HOLD      = 3'd0,
      WAIT_LOCK = 3'd1,
      SETTLE    = 3'd2,
      RUN       = 3'd3,
      REARM     = 3'd4
   } state_t;

   state_t                 state, state_n;
   logic [TW-1:0]          timer;
   logic [SYNC_STAGES-1:0] lk_q, st_q, ur_q;
   logic                   lk_s, st_s, ur_s, lock_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lk_q <= '0;
         st_q <= '0;
         ur_q <= '0;
      end else begin
         lk_q <= {lk_q[SYNC_STAGES-2:0], bus.pll_locked};
         st_q <= {st_q[SYNC_STAGES-2:0], bus.pll_locked_stdy};
         ur_q <= {ur_q[SYNC_STAGES-2:0], bus.usr_rstn};
      end
   end

   assign lk_s    = lk_q[SYNC_STAGES-1];
   assign st_s    = st_q[SYNC_STAGES-1];
   assign ur_s    = ur_q[SYNC_STAGES-1];
   assign lock_ok = lk_s & st_s;

   // User reset overrides every other transition.
   always_comb begin
      state_n = state;
      if (!ur_s) begin
         state_n = HOLD;
      end else begin
         case (state)
            HOLD:      state_n = WAIT_LOCK;
            WAIT_LOCK: begin
               if (lock_ok)
                  state_n = SETTLE;
               else if ((LOCK_TIMEOUT != 0) && (timer == TW'(LOCK_TIMEOUT - 1)))
                  state_n = REARM;
            end
            SETTLE: begin
               if (!lock_ok)
                  state_n = REARM;
               else if (timer == TW'(SETTLE_CYCLES - 1))
                  state_n = RUN;
            end
            RUN: begin
               if (!lock_ok)
                  state_n = REARM;
            end
            REARM: begin
               if (timer == TW'(REARM_CYCLES - 1))
                  state_n = WAIT_LOCK;
            end
            default:   state_n = HOLD;
         endcase
      end
   end

   // Timer restarts on each state change and saturates rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HOLD;
         timer <= '0;
      end else begin
         state <= state_n;
         if (state_n != state)
            timer <= '0;
         else if (timer != {TW{1'b1}})
            timer <= timer + 1'b1;
      end
   end

   assign bus.sys_rst         = (state != RUN);
   assign bus.sys_rstn        = (state == RUN);
   assign bus.ready           = (state == RUN);
   assign bus.locked_stdy_rst = (state == HOLD) || (state == REARM);

`ifdef CC_RSTSEQ_LOSS_CNT_EN
   logic [CNT_W-1:0] loss_cnt;
   logic             loss_evt;

   // Counts a loss seen in RUN even when the user reset wins the transition.
   assign loss_evt = (state == RUN) && !lock_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         loss_cnt <= '0;
      else if (loss_evt && (loss_cnt != {CNT_W{1'b1}}))
         loss_cnt <= loss_cnt + 1'b1;
   end

   assign bus.loss_cnt = loss_cnt;
`else
   assign bus.loss_cnt = {CNT_W{1'b0}};
`endif

endmodule
